// File: rtl/char_plane_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// char_plane_pkg: shared op codes, control glyphs and FSM states for the plane
// Rev 1.0
// ----------------------------------------------------------------------------
package char_plane_pkg;

    localparam logic [1:0] OP_WRITE_AT = 2'd0;
    localparam logic [1:0] OP_PUT      = 2'd1;
    localparam logic [1:0] OP_CLEAR    = 2'd2;
    localparam logic [1:0] OP_SCROLL   = 2'd3;

    localparam logic [7:0] CH_NEWLINE  = 8'h0A;
    localparam logic [7:0] CH_ERASE    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SCROLL = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/char_plane_cursor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// char_plane_cursor: cursor registers and PUT position/newline/backspace logic
// Rev 1.0
// ----------------------------------------------------------------------------
module char_plane_cursor
    import char_plane_pkg::*;
#(
    parameter int ROWS   = 7,
    parameter int COLS   = 20,
    parameter int CHAR_W = 8,
    parameter int ROW_W  = $clog2(ROWS),
    parameter int COL_W  = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              put_i,
    input  logic              home_i,
    input  logic [CHAR_W-1:0] char_i,
    output logic [ROW_W-1:0]  cur_row_o,
    output logic [COL_W-1:0]  cur_col_o,
    output logic              wr_en_o,
    output logic              wr_erase_o,
    output logic [ROW_W-1:0]  wr_row_o,
    output logic [COL_W-1:0]  wr_col_o,
    output logic              wrap_o
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             newline;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        newline    = 1'b0;
        wrap_o     = 1'b0;
        wr_en_o    = 1'b0;
        wr_erase_o = 1'b0;
        wr_row_o   = row_q;
        wr_col_o   = col_q;
        if (home_i) begin
            row_d = '0;
            col_d = '0;
        end else if (put_i) begin
            if (char_i == CHAR_W'(CH_NEWLINE)) begin
                newline = 1'b1;
            end else if (char_i == CHAR_W'(CH_ERASE)) begin
                // Backspace erases the cell it lands on, not the one it left.
                wr_en_o    = 1'b1;
                wr_erase_o = 1'b1;
                if (col_q != '0) begin
                    col_d = col_q - 1'b1;
                end else if (row_q != '0) begin
                    row_d = row_q - 1'b1;
                    col_d = LAST_COL;
                end
                wr_row_o = row_d;
                wr_col_o = col_d;
            end else begin
                wr_en_o = 1'b1;
                if (col_q == LAST_COL) begin
                    newline = 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            if (newline) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                    wrap_o = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
        end
    end

    assign cur_row_o = row_q;
    assign cur_col_o = col_q;

endmodule
`default_nettype wire

// File: rtl/char_plane_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// char_plane_ctrl: ROWS x COLS glyph plane with command port, cursor and sweeps
// Rev 1.0
// ----------------------------------------------------------------------------
module char_plane_ctrl
    import char_plane_pkg::*;
#(
    parameter int ROWS   = 7,
    parameter int COLS   = 20,
    parameter int CHAR_W = 8,
    parameter int BLANK  = 129,
    parameter int ROW_W  = $clog2(ROWS),
    parameter int COL_W  = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ROW_W-1:0]  cmd_row,
    input  logic [COL_W-1:0]  cmd_col,
    input  logic [CHAR_W-1:0] cmd_char,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [CHAR_W-1:0] rd_data,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic              busy
);

    localparam int                CELLS     = ROWS * COLS;
    localparam int                ADDR_W    = $clog2(CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] SHIFT_END = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [CHAR_W-1:0] BLANK_C   = CHAR_W'(BLANK);

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    function automatic logic in_range(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return ({1'b0, r} < (ROW_W + 1)'(ROWS)) && ({1'b0, c} < (COL_W + 1)'(COLS));
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic [CHAR_W-1:0]   mem [CELLS];
    logic [CHAR_W-1:0]   rd_data_q;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [CHAR_W-1:0]   mem_wdata;
    logic                put, home, wrap;
    logic                cur_wr_en, cur_wr_erase;
    logic [ROW_W-1:0]    cur_wr_row;
    logic [COL_W-1:0]    cur_wr_col;

    assign put  = cmd_valid && (state_q == ST_IDLE) && (cmd_op == OP_PUT);
    assign home = (state_q == ST_CLEAR) && (sweep_q == LAST_CELL);

    char_plane_cursor #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .CHAR_W (CHAR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_cursor (
        .clk        (clk),
        .rst_n      (reset),
        .put_i      (put),
        .home_i     (home),
        .char_i     (cmd_char),
        .cur_row_o  (cur_row),
        .cur_col_o  (cur_col),
        .wr_en_o    (cur_wr_en),
        .wr_erase_o (cur_wr_erase),
        .wr_row_o   (cur_wr_row),
        .wr_col_o   (cur_wr_col),
        .wrap_o     (wrap)
    );

    // Reset parks the FSM in CLEAR so the plane is blanked after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            sweep_q   <= '0;
            rd_data_q <= BLANK_C;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            rd_data_q <= in_range(rd_row, rd_col) ? mem[lin_addr(rd_row, rd_col)] : BLANK_C;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        mem_we    = 1'b0;
        mem_waddr = sweep_q;
        mem_wdata = BLANK_C;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE_AT: begin
                            mem_we    = in_range(cmd_row, cmd_col);
                            mem_waddr = lin_addr(cmd_row, cmd_col);
                            mem_wdata = (cmd_char == CHAR_W'(CH_ERASE)) ? BLANK_C : cmd_char;
                        end
                        OP_PUT: begin
                            mem_we    = cur_wr_en;
                            mem_waddr = lin_addr(cur_wr_row, cur_wr_col);
                            mem_wdata = cur_wr_erase ? BLANK_C : cmd_char;
                            if (wrap) begin
                                state_d = ST_SCROLL;
                                sweep_d = '0;
                            end
                        end
                        OP_CLEAR: begin
                            state_d = ST_CLEAR;
                            sweep_d = '0;
                        end
                        default: begin
                            state_d = ST_SCROLL;
                            sweep_d = '0;
                        end
                    endcase
                end
            end
            ST_CLEAR, ST_SCROLL: begin
                mem_we = 1'b1;
                // Lower cells are rewritten first, so the source row is still intact.
                if ((state_q == ST_SCROLL) && (sweep_q < SHIFT_END)) begin
                    mem_wdata = mem[sweep_q + ADDR_W'(COLS)];
                end
                if (sweep_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
        if (!reset) begin
            mem_we = 1'b0;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_char_plane_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_char_plane_ctrl: randomized scoreboard bench against a 2-D plane model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_char_plane_ctrl;

    localparam int ROWS  = 7;
    localparam int COLS  = 20;
    localparam int BLANK = 129;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [2:0] cmd_row = '0;
    logic [4:0] cmd_col = '0;
    logic [7:0] cmd_char = '0;
    logic [2:0] rd_row = '0;
    logic [4:0] rd_col = '0;
    logic [7:0] rd_data;
    logic [2:0] cur_row;
    logic [4:0] cur_col;
    logic       busy;

    always #5 clk = ~clk;

    char_plane_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .CHAR_W(8), .BLANK(BLANK)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_char(cmd_char),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int model [ROWS][COLS];
    int mr = 0;
    int mc = 0;
    int last_wait = 0;
    int exp_q[$];
    int tag_q[$];
    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) model[r][c] = BLANK;
        mr = 0;
        mc = 0;
    endfunction

    function automatic void model_scroll();
        for (int r = 0; r < ROWS - 1; r++) model[r] = model[r + 1];
        for (int c = 0; c < COLS; c++) model[ROWS - 1][c] = BLANK;
    endfunction

    function automatic void model_write(input int r, input int c, input int ch);
        if (r < ROWS && c < COLS) model[r][c] = (ch == 255) ? BLANK : ch;
    endfunction

    function automatic bit model_newline();
        mc = 0;
        if (mr == ROWS - 1) begin
            model_scroll();
            return 1'b1;
        end
        mr++;
        return 1'b0;
    endfunction

    function automatic bit model_put(input int ch);
        if (ch == 8'h0A) return model_newline();
        if (ch == 8'hFF) begin
            if (mc > 0) mc--;
            else if (mr > 0) begin mr--; mc = COLS - 1; end
            model[mr][mc] = BLANK;
            return 1'b0;
        end
        model[mr][mc] = ch;
        if (mc == COLS - 1) return model_newline();
        mc++;
        return 1'b0;
    endfunction

    // ---------------- read scoreboard ----------------
    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (rd_req_d) begin
            if (exp_q.size() == 0) begin
                chk("read_no_expectation", 1, 0);
            end else begin
                int e;
                int t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (rd_data !== e[7:0]) begin
                    errors++;
                    $display("FAIL read(r%0d,c%0d) actual=%0d required=%0d", t / 100, t % 100, rd_data, e);
                end
            end
        end
    end

    task automatic rd(input int r, input int c);
        rd_row = r[2:0];
        rd_col = c[4:0];
        rd_req = 1'b1;
        exp_q.push_back((r < ROWS && c < COLS) ? model[r][c] : BLANK);
        tag_q.push_back(r * 100 + c);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic rd_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) rd(r, c);
    endtask

    task automatic wait_sweep(input string nm);
        int n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk(nm, n, ROWS * COLS);
    endtask

    task automatic chk_cursor(input string nm);
        chk({nm, "_row"}, int'(cur_row), mr);
        chk({nm, "_col"}, int'(cur_col), mc);
    endtask

    // Issue one command from a negedge; fields are held until accepted.
    task automatic send(input int op, input int r, input int c, input int ch, input bit hold_sweep);
        int n = 0;
        bit sweep = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_row   = r[2:0];
        cmd_col   = c[4:0];
        cmd_char  = ch[7:0];
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        case (op)
            0: model_write(r, c, ch);
            1: sweep = model_put(ch);
            2: begin model_clear(); sweep = 1'b1; end
            default: begin model_scroll(); sweep = 1'b1; end
        endcase
        if (sweep && !hold_sweep) wait_sweep("sweep_len");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 1);
        chk("reset_ready", int'(cmd_ready), 0);
        chk("reset_rd_data", int'(rd_data), BLANK);
        chk("reset_cur_row", int'(cur_row), 0);
        chk("reset_cur_col", int'(cur_col), 0);
        reset = 1'b1;
        wait_sweep("init_clear_len");
        chk("init_ready", int'(cmd_ready), 1);
        model_clear();
        rd_all();

        // Directed WRITE_AT, erase and out-of-range writes
        send(0, 2, 5, 65, 1'b0);
        rd(2, 5);
        send(0, 2, 5, 255, 1'b0);
        rd(2, 5);
        send(0, 7, 0, 66, 1'b0);
        send(0, 3, 25, 66, 1'b0);
        rd(7, 0);
        rd_all();

        // Directed PUT: line wrap, newline, backspace across rows
        for (int i = 0; i < COLS; i++) send(1, 0, 0, 8'h78, 1'b0);
        chk_cursor("put_wrap");
        send(1, 0, 0, 8'h0A, 1'b0);
        chk_cursor("put_nl");
        send(1, 0, 0, 8'hFF, 1'b0);
        chk_cursor("put_bs");
        chk("put_bs_row_abs", int'(cur_row), 1);
        chk("put_bs_col_abs", int'(cur_col), 19);
        rd(1, 19);
        rd(1, 18);

        // Randomized command mix against the model
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 45) begin
                send(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 23)),
                     ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 254)), 1'b0);
            end else if (sel < 92) begin
                int k;
                int ch;
                k = int'($urandom_range(0, 9));
                ch = (k == 0) ? 8'h0A : (k == 1) ? 8'hFF : int'($urandom_range(32, 126));
                send(1, 0, 0, ch, 1'b0);
            end else if (sel < 96) begin
                send(3, 0, 0, 0, 1'b0);
            end else begin
                send(2, 0, 0, 0, 1'b0);
            end
            chk_cursor("rand_cursor");
            rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 23)));
        end
        rd_all();

        // Fill with row ids, then newline on the last row forces a scroll
        send(2, 0, 0, 0, 1'b0);
        chk_cursor("clear_home");
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) send(0, r, c, r, 1'b0);
        for (int i = 0; i < ROWS - 1; i++) send(1, 0, 0, 8'h0A, 1'b0);
        chk("fill_cur_row", int'(cur_row), 6);
        send(1, 0, 0, 8'h0A, 1'b0);
        chk("scroll_cur_row", int'(cur_row), 6);
        chk("scroll_cur_col", int'(cur_col), 0);
        rd_all();

        // WRITE_AT held across an explicit SCROLL lands on the first idle cycle
        send(1, 0, 0, 8'h51, 1'b0);
        send(3, 0, 0, 0, 1'b1);
        send(0, 4, 4, 77, 1'b0);
        chk("held_write_wait", last_wait, ROWS * COLS);
        chk_cursor("held_cursor");
        rd(4, 4);
        rd_all();

        // Reset in the middle of a SCROLL sweep aborts it and reclears
        send(3, 0, 0, 0, 1'b1);
        repeat (50) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("abort_cur_row", int'(cur_row), 0);
        chk("abort_cur_col", int'(cur_col), 0);
        chk("abort_rd_data", int'(rd_data), BLANK);
        chk("abort_ready", int'(cmd_ready), 0);
        chk("abort_busy", int'(busy), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_sweep("reclear_len");
        model_clear();
        rd_all();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
